// File: rtl/coeff_ramblk_pkg.sv
// Shared types and default sizing for the coefficient RAM block reader.
package coeff_ramblk_pkg;

    localparam int unsigned DEF_ADDR_W     = 10;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_RD_LATENCY = 2;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/coeff_ramblk_reader_fifo.sv
// Output skid FIFO: synchronous, combinational head read, flush beats push/pop.
module coeff_skid_fifo
    import coeff_ramblk_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);

endmodule

// File: rtl/coeff_ramblk_reader.sv
// Streams load_count coefficient words from RAM port A (addresses 0..N-1)
// through a credit-limited read pipeline and skid FIFO onto a ready/valid stream.
module coeff_ramblk_reader
    import coeff_ramblk_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned RD_LATENCY = DEF_RD_LATENCY,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_count,
    input  logic              abort,
    output logic              bram_en_a,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wr_data,
    input  logic [DATA_W-1:0] bram_rd_data,
    output logic [DATA_W-1:0] coeff_data,
    output logic              coeff_valid,
    input  logic              coeff_ready,
    output logic              coeff_last,
    output logic [ADDR_W-1:0] coeff_idx,
    output logic              busy,
    output logic              done,
    output logic              err_busy_start
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;
    localparam int unsigned ENT_W = DATA_W + ADDR_W + 1;
    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     rd_ptr;
    logic [ADDR_W-1:0]   push_idx;
    logic [RD_LATENCY-1:0] vld_sr;
    logic [OCC_W-1:0]    inflight;
    logic [OCC_W-1:0]    occupancy;
    logic [CNT_W-1:0]    fifo_count;
    logic                start_req;
    logic                issue;
    logic                push;
    logic                pop;
    logic                flush;
    logic                fifo_empty;
    logic                err_q;
    logic [ENT_W-1:0]    push_ent;
    logic [ENT_W-1:0]    pop_ent;

    assign start_req = load_start && (state == IDLE)
                       && (load_count != '0) && (load_count <= MAX_COUNT);
    assign flush     = abort && ((state == RUN) || (state == DRAIN));

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + OCC_W'(vld_sr[i]);
        end
    end

    // Credit check: every issued read must already own a FIFO slot when it lands.
    assign occupancy = OCC_W'(fifo_count) + inflight - OCC_W'(pop);
    assign issue     = (state == RUN) && !abort && (rd_ptr < count_q)
                       && (occupancy < OCC_W'(FIFO_DEPTH));

    assign push     = vld_sr[RD_LATENCY-1];
    assign push_ent = {bram_rd_data, push_idx, ({1'b0, push_idx} == count_q - 1'b1)};
    assign pop      = coeff_valid && coeff_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count_q  <= '0;
            rd_ptr   <= '0;
            push_idx <= '0;
            vld_sr   <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (load_start && (state != IDLE)) begin
                err_q <= 1'b1;
            end else if (start_req) begin
                err_q <= 1'b0;
            end
            if (start_req) begin
                count_q  <= load_count;
                rd_ptr   <= '0;
                push_idx <= '0;
            end else begin
                if (issue) rd_ptr   <= rd_ptr + 1'b1;
                if (push)  push_idx <= push_idx + 1'b1;
            end
            if (flush) begin
                vld_sr <= '0;
            end else begin
                vld_sr[0] <= issue;
                for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                    vld_sr[i] <= vld_sr[i-1];
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_req) state_nx = RUN;
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (issue && (rd_ptr + 1'b1 == count_q)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (pop && coeff_last) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    coeff_skid_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (push_ent),
        .pop       (pop),
        .pop_data  (pop_ent),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign coeff_valid    = !fifo_empty;
    assign coeff_data     = coeff_valid ? pop_ent[ENT_W-1 -: DATA_W] : '0;
    assign coeff_idx      = coeff_valid ? pop_ent[ADDR_W:1] : '0;
    assign coeff_last     = coeff_valid && pop_ent[0];

    assign bram_en_a      = issue;
    assign bram_addr      = issue ? rd_ptr[ADDR_W-1:0] : '0;
    assign bram_we        = 1'b0;
    assign bram_wr_data   = '0;
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign err_busy_start = err_q;

endmodule

// File: tb/tb_coeff_ramblk_reader.sv
// Self-checking bench: RAM model, scoreboard queue, table-driven loads and corner sequences.
module tb_coeff_ramblk_reader;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CW     = ADDR_W + 1;
    localparam int unsigned WORDS  = 1 << ADDR_W;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] idx;
        logic              last;
    } word_t;

    typedef struct {
        int unsigned cnt;
        int unsigned pct;
        bit          accept;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start;
    logic [ADDR_W:0]   load_count;
    logic              abort;
    logic              bram_en_a;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wr_data;
    logic [DATA_W-1:0] bram_rd_data;
    logic [DATA_W-1:0] coeff_data;
    logic              coeff_valid;
    logic              coeff_ready = 1'b1;
    logic              coeff_last;
    logic [ADDR_W-1:0] coeff_idx;
    logic              busy;
    logic              done;
    logic              err_busy_start;

    logic [DATA_W-1:0] ram [WORDS];
    logic [DATA_W-1:0] ram_q1;

    word_t       exp_q[$];
    vec_t        vecs [7];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned rx_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned ready_pct = 100;

    int unsigned t_ls = 0;
    int unsigned exp_n = 0;
    int unsigned last_cn = 0;
    int unsigned cn;
    bit          en_pend = 0;
    bit          first_pend = 0;
    bit          prev_stall = 0;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W-1:0] prev_idx;
    logic              prev_last;
    word_t             mon_w;

    coeff_ramblk_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LAT),
        .FIFO_DEPTH (DEPTH)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_start     (load_start),
        .load_count     (load_count),
        .abort          (abort),
        .bram_en_a      (bram_en_a),
        .bram_we        (bram_we),
        .bram_addr      (bram_addr),
        .bram_wr_data   (bram_wr_data),
        .bram_rd_data   (bram_rd_data),
        .coeff_data     (coeff_data),
        .coeff_valid    (coeff_valid),
        .coeff_ready    (coeff_ready),
        .coeff_last     (coeff_last),
        .coeff_idx      (coeff_idx),
        .busy           (busy),
        .done           (done),
        .err_busy_start (err_busy_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Two-stage read pipeline: core register then output register.
    always @(posedge clk) begin
        if (bram_en_a) ram_q1 <= ram[bram_addr];
        bram_rd_data <= ram_q1;
    end

    always @(posedge clk) begin
        #1;
        coeff_ready = ($urandom_range(99) < ready_pct);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: compares every accepted word, stall stability and cycle timing.
    always @(negedge clk) begin
        cn = cyc + 1;
        if (!rst_n || abort) begin
            prev_stall = 0;
            en_pend    = 0;
            first_pend = 0;
        end else begin
            if (en_pend) begin
                chk("en_at_T1", bram_en_a, 1);
                chk("addr0_at_T1", bram_addr, 0);
                en_pend = 0;
            end
            if (load_start && !busy && load_count != 0 && load_count <= CW'(WORDS)) begin
                t_ls = cn;
                exp_n = load_count;
                en_pend = 1;
                first_pend = 1;
            end
            if (coeff_valid && first_pend) begin
                first_pend = 0;
                chk("first_valid_cycle", cn, t_ls + 4);
            end
            if (prev_stall) begin
                chk("stall_valid", coeff_valid, 1);
                chk("stall_data", coeff_data, prev_data);
                chk("stall_idx", coeff_idx, prev_idx);
                chk("stall_last", coeff_last, prev_last);
            end
            if (coeff_valid && coeff_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual_idx=%0d required=none", coeff_idx);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("word_data", coeff_data, mon_w.data);
                    chk("word_idx", coeff_idx, mon_w.idx);
                    chk("word_last", coeff_last, mon_w.last);
                    rx_cnt++;
                    if (mon_w.last) begin
                        last_cn = cn;
                        if (ready_pct == 100) chk("last_cycle", cn, t_ls + 3 + exp_n);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last", cn, last_cn + 1);
            end
            if (busy) chk("fifo_le_depth", u_dut.fifo_count <= DEPTH, 1);
            prev_stall = coeff_valid && !coeff_ready;
            prev_data  = coeff_data;
            prev_idx   = coeff_idx;
            prev_last  = coeff_last;
        end
    end

    task automatic push_expected(input int unsigned n);
        word_t w;
        for (int unsigned i = 0; i < n; i++) begin
            w.data = DATA_W'(i * 3);
            w.idx  = ADDR_W'(i);
            w.last = (i == n - 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic start_load(input int unsigned n, input int unsigned pct, input bit accept);
        ready_pct = pct;
        @(posedge clk);
        #1;
        rx_cnt = 0;
        load_start = 1'b1;
        load_count = CW'(n);
        if (accept) push_expected(n);
        @(posedge clk);
        #1;
        load_start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy, accept);
    endtask

    task automatic wait_done(input int unsigned d0, input int unsigned limit);
        for (int unsigned i = 0; i < limit; i++) begin
            @(posedge clk);
            if (done_cnt != d0) break;
        end
        chk("done_seen", done_cnt - d0, 1);
    endtask

    task automatic wait_rx(input int unsigned n, input int unsigned limit);
        for (int unsigned i = 0; i < limit; i++) begin
            @(posedge clk);
            if (rx_cnt >= n) break;
        end
        chk("rx_reached", rx_cnt >= n, 1);
    endtask

    task automatic run_load(input int unsigned n, input int unsigned pct, input bit accept);
        int unsigned d0;
        d0 = done_cnt;
        start_load(n, pct, accept);
        if (accept) begin
            wait_done(d0, n * 8 + 50);
            chk("queue_drained", exp_q.size(), 0);
            chk("rx_count", rx_cnt, n);
        end else begin
            repeat (5) @(negedge clk);
            chk("ignored_no_done", done_cnt, d0);
            chk("ignored_no_valid", coeff_valid, 0);
        end
    endtask

    task automatic check_reset(input string p);
        chk({p, "_en"}, bram_en_a, 0);
        chk({p, "_we"}, bram_we, 0);
        chk({p, "_addr"}, bram_addr, 0);
        chk({p, "_wdata"}, bram_wr_data, 0);
        chk({p, "_valid"}, coeff_valid, 0);
        chk({p, "_last"}, coeff_last, 0);
        chk({p, "_idx"}, coeff_idx, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_err"}, err_busy_start, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned d0;
        vecs[0] = '{cnt: 0,    pct: 100, accept: 1'b0};
        vecs[1] = '{cnt: 1025, pct: 100, accept: 1'b0};
        vecs[2] = '{cnt: 1,    pct: 100, accept: 1'b1};
        vecs[3] = '{cnt: 2,    pct: 100, accept: 1'b1};
        vecs[4] = '{cnt: 1024, pct: 100, accept: 1'b1};
        vecs[5] = '{cnt: 100,  pct: 50,  accept: 1'b1};
        vecs[6] = '{cnt: 7,    pct: 30,  accept: 1'b1};
        for (int unsigned i = 0; i < WORDS; i++) ram[i] = DATA_W'(i * 3);

        rst_n = 1'b0;
        load_start = 1'b0;
        load_count = '0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int unsigned v = 0; v < 7; v++) begin
            run_load(vecs[v].cnt, vecs[v].pct, vecs[v].accept);
        end

        // load_start while streaming flags the error without disturbing the load
        d0 = done_cnt;
        start_load(100, 100, 1'b1);
        wait_rx(10, 100);
        #1 load_start = 1'b1;
        load_count = CW'(5);
        @(posedge clk);
        #1 load_start = 1'b0;
        @(negedge clk);
        chk("err_set", err_busy_start, 1);
        wait_done(d0, 400);
        chk("err_kept", err_busy_start, 1);
        chk("busy_q_drained", exp_q.size(), 0);
        d0 = done_cnt;
        start_load(3, 100, 1'b1);
        chk("err_cleared", err_busy_start, 0);
        wait_done(d0, 100);

        // abort at word 50
        start_load(200, 100, 1'b1);
        wait_rx(50, 200);
        d0 = done_cnt;
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_valid", coeff_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_no_valid", coeff_valid, 0);
        run_load(4, 100, 1'b1);

        // reset pulse mid-load, after setting the sticky error
        start_load(300, 100, 1'b1);
        wait_rx(10, 100);
        #1 load_start = 1'b1;
        load_count = CW'(5);
        @(posedge clk);
        #1 load_start = 1'b0;
        @(negedge clk);
        chk("err_set_2", err_busy_start, 1);
        wait_rx(20, 100);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset("midrst");
        for (int unsigned i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_valid_after_reset", coeff_valid, 0);
        end
        run_load(3, 100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coeff_ramblk_reader.md
COEFF_RAMBLK_READER -- requirements
Module: coeff_ramblk_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, the coefficient RAM port-A address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, the coefficient word width.
REQ-003 The block SHALL have parameter RD_LATENCY, default 2, the port-A cycles from bram_en_a to valid bram_rd_data (core and primitive output registers enabled).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, the output skid FIFO depth, constrained to at least RD_LATENCY+2.
REQ-005 The block SHALL use one clock, clk; reset is synchronous and active-low, rst_n.
REQ-006 Port clk, input, 1 bit: the single clock.
REQ-007 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-008 Port load_start, input, 1 bit: single-cycle request to stream coefficients.
REQ-009 Port load_count, input, ADDR_W+1 bits: number of words to read, 1..2^ADDR_W, sampled with load_start.
REQ-010 Port abort, input, 1 bit: terminates an in-progress load.
REQ-011 Port bram_en_a, output, 1 bit: port-A read enable.
REQ-012 Port bram_we, output, 1 bit: port-A write enable, constant 0.
REQ-013 Port bram_addr, output, ADDR_W bits: port-A word address.
REQ-014 Port bram_wr_data, output, DATA_W bits: port-A write data, constant 0.
REQ-015 Port bram_rd_data, input, DATA_W bits: port-A read data.
REQ-016 Port coeff_data, output, DATA_W bits: coefficient stream data.
REQ-017 Port coeff_valid, output, 1 bit: the coefficient stream holds a word.
REQ-018 Port coeff_ready, input, 1 bit: the consumer accepts a word.
REQ-019 Port coeff_last, output, 1 bit: marks the final word of a load.
REQ-020 Port coeff_idx, output, ADDR_W bits: RAM address of the current word.
REQ-021 Port busy, output, 1 bit: high outside IDLE.
REQ-022 Port done, output, 1 bit: one-cycle pulse after the last word is accepted.
REQ-023 Port err_busy_start, output, 1 bit: sticky flag for a load_start received while busy.

Function
REQ-024 FSM states SHALL be IDLE, RUN (issuing reads), DRAIN (all reads issued, FIFO not empty), and DONE (single cycle, done=1, then IDLE).
REQ-025 In IDLE, load_start with load_count in 1..2^ADDR_W SHALL latch the count, clear the read/out counters, and enter RUN.
REQ-026 In IDLE, load_start with load_count=0 or load_count >2^ADDR_W SHALL be ignored.
REQ-027 In RUN, a read SHALL issue (bram_en_a=1, bram_addr=rd_ptr, rd_ptr+1) only when fifo_count + inflight − pop < FIFO_DEPTH.
REQ-028 After load_count reads are issued, RUN SHALL go to DRAIN; DRAIN SHALL go to DONE in the cycle the last word is popped.
REQ-029 Read data SHALL be pushed into the FIFO exactly RD_LATENCY cycles after its enable, via a RD_LATENCY-deep valid shift register; the FIFO SHALL never overflow.
REQ-030 Stream handshake: a word transfers when coeff_valid and coeff_ready are both high; coeff_data, coeff_idx and coeff_last SHALL remain stable while coeff_valid=1 and coeff_ready=0.
REQ-031 Words SHALL appear in address order 0..load_count−1; coeff_last SHALL be high only with coeff_idx=load_count−1.
REQ-032 Latency: with coeff_ready=1 held, load_start sampled at edge T SHALL give bram_en_a high in cycle T+1 and the first coeff_valid by cycle T+1+RD_LATENCY+1, followed by one word per cycle.
REQ-033 load_start while busy SHALL be ignored and set err_busy_start, which is cleared only by reset or by an accepted load_start in IDLE.
REQ-034 abort SHALL, on the next edge, stop issuing reads, discard in-flight reads, flush the FIFO, return to IDLE without done, and take priority over a simultaneous pop.
REQ-035 A rd_ptr value of 2^ADDR_W SHALL never be driven; no wrap-around SHALL occur within a load.

Reset
REQ-036 While rst_n=0 at an edge: state=IDLE, FIFO and valid pipeline empty, counters 0; bram_en_a, bram_we, coeff_valid, coeff_last, busy, done and err_busy_start =0; bram_addr, bram_wr_data, coeff_idx =0.
REQ-037 Reset asserted mid-load SHALL abandon the load; no stale word SHALL appear after release.

Structure
REQ-038 Package coeff_ramblk_pkg SHALL hold the FSM state enum and the default ADDR_W, DATA_W, RD_LATENCY and FIFO_DEPTH constants.
REQ-039 The output buffer SHALL be one sub-module, coeff_skid_fifo (synchronous, count output, flush input).

Verification
REQ-040 Preload RAM[i]=i*3; load_count=1024, ready=1 -> 1024 words in order, first valid at T+4, last at T+1027, coeff_last only at idx 1023, done one cycle later.
REQ-041 load_count=1 -> single word RAM[0], with coeff_valid and coeff_last together, then done.
REQ-042 Random ready (50%), load_count=100 -> no loss or duplication; data stable while stalled; FIFO count never exceeds 4.
REQ-043 load_start at word 10 of a running load -> err_busy_start=1, stream unaffected; the next idle load_start clears it.
REQ-044 abort at word 50 -> coeff_valid=0 next cycle, no done, busy=0; a new load starts at address 0.
REQ-045 rst_n=0 for 1 cycle mid-load -> all outputs at reset values; no valid until the next load_start.
